// File: rtl/enc_pkg.sv
// Shared types and constants for the RV32I instruction encoder.
// Holds op classes, base opcodes, the canonical NOP, FSM states and the field bundle.
// Also provides a signed-range helper used when immediate range checking is built in.
package enc_pkg;

    typedef enum logic [2:0] {
        OP_R      = 3'd0,
        OP_LOAD   = 3'd1,
        OP_OPIMM  = 3'd2,
        OP_STORE  = 3'd3,
        OP_BRANCH = 3'd4,
        OP_JAL    = 3'd5,
        OP_JALR   = 3'd6,
        OP_ILL    = 3'd7
    } op_e;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_FULL
    } state_e;

    typedef struct packed {
        op_e         op;
        logic [2:0]  fn3;
        logic [6:0]  fn7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } fields_t;

    // True when v, read as a signed 32-bit value, fits in a signed field of 'bits' bits.
    function automatic logic fits_signed(input logic [31:0] v, input int bits);
        int lo;
        int hi;
        lo = -(1 << (bits - 1));
        hi = (1 << (bits - 1)) - 1;
        return ($signed(v) >= lo) && ($signed(v) <= hi);
    endfunction

endpackage

// File: rtl/instr_format_pack.sv
// Combinational packer: field bundle -> 32-bit RV32I word, NOP plus err on illegal op.
// Latency: zero cycles (pure combinational).
// Backpressure: none; caller decides when the word is captured.
// Ports: f (field bundle in), word (encoded instruction out), err (word replaced by NOP).
// Build option IMM_RANGE_CHECK_EN: out-of-range immediates also yield NOP with err.
module instr_format_pack
    import enc_pkg::*;
(
    input  fields_t     f,
    output logic [31:0] word,
    output logic        err
);

    logic range_ok;

`ifdef IMM_RANGE_CHECK_EN
    // Branch and jump offsets are in bytes and must be halfword aligned.
    always_comb begin
        range_ok = 1'b1;
        case (f.op)
            OP_LOAD, OP_OPIMM, OP_JALR, OP_STORE: range_ok = fits_signed(f.imm, 12);
            OP_BRANCH: range_ok = fits_signed(f.imm, 13) && !f.imm[0];
            OP_JAL:    range_ok = fits_signed(f.imm, 21) && !f.imm[0];
            default:   range_ok = 1'b1;
        endcase
    end
`else
    // High immediate bits are simply truncated by every format.
    logic unused_imm_hi;
    assign unused_imm_hi = ^f.imm[31:21];
    assign range_ok      = 1'b1;
`endif

    always_comb begin
        word = NOP_INSTR;
        err  = 1'b0;
        case (f.op)
            OP_R:      word = {f.fn7, f.rs2, f.rs1, f.fn3, f.rd, OPC_R};
            OP_LOAD:   word = {f.imm[11:0], f.rs1, f.fn3, f.rd, OPC_LOAD};
            OP_OPIMM:  word = {f.imm[11:0], f.rs1, f.fn3, f.rd, OPC_OPIMM};
            OP_JALR:   word = {f.imm[11:0], f.rs1, 3'b000, f.rd, OPC_JALR};
            OP_STORE:  word = {f.imm[11:5], f.rs2, f.rs1, f.fn3, f.imm[4:0], OPC_STORE};
            OP_BRANCH: word = {f.imm[12], f.imm[10:5], f.rs2, f.rs1, f.fn3,
                               f.imm[4:1], f.imm[11], OPC_BRANCH};
            OP_JAL:    word = {f.imm[20], f.imm[10:1], f.imm[11], f.imm[19:12],
                               f.rd, OPC_JAL};
            default: begin
                word = NOP_INSTR;
                err  = 1'b1;
            end
        endcase
        if (!range_ok) begin
            word = NOP_INSTR;
            err  = 1'b1;
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Packs field bundles into RV32I words and writes them to sequential instruction-memory addresses.
// Latency: bundle accepted in cycle N -> wr_en/wr_data in N+1; one word per two cycles.
// Backpressure: in_ready high only in LOAD; held low while writing, idle, or after DEPTH words.
// Ports: clk/rst (sync, active high); start; in_valid/in_ready + op/fn3/fn7/rd/rs1/rs2/imm;
//        wr_en/wr_addr/wr_data memory write port; count, full, err status.
// Build option IMM_RANGE_CHECK_EN enables immediate range checking in instr_format_pack.
module instr_encoder
    import enc_pkg::*;
#(
    parameter int D_WIDTH   = 32,
    parameter int A_WIDTH   = 10,
    parameter int DEPTH     = 256,
    parameter int BASE_ADDR = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         op,
    input  logic [2:0]         fn3,
    input  logic [6:0]         fn7,
    input  logic [4:0]         rd,
    input  logic [4:0]         rs1,
    input  logic [4:0]         rs2,
    input  logic [D_WIDTH-1:0] imm,
    output logic               wr_en,
    output logic [A_WIDTH-1:0] wr_addr,
    output logic [D_WIDTH-1:0] wr_data,
    output logic [A_WIDTH-2:0] count,
    output logic               full,
    output logic               err
);

    localparam logic [A_WIDTH-1:0] BASE = A_WIDTH'(BASE_ADDR);
    localparam logic [A_WIDTH-2:0] LAST = (A_WIDTH-1)'(DEPTH - 1);

    state_e      state;
    state_e      state_nxt;
    fields_t     fields;
    logic [31:0] pack_word;
    logic        pack_err;
    logic        accept;

    assign fields = '{op: op_e'(op), fn3: fn3, fn7: fn7, rd: rd,
                      rs1: rs1, rs2: rs2, imm: imm};

    instr_format_pack u_pack (
        .f    (fields),
        .word (pack_word),
        .err  (pack_err)
    );

    // start takes priority over a coincident handshake; that bundle is dropped.
    assign accept   = (state == S_LOAD) && in_valid && !start;
    assign in_ready = (state == S_LOAD);
    assign full     = (state == S_FULL);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_LOAD;
            S_LOAD:  if (start) state_nxt = S_LOAD;
                     else if (in_valid) state_nxt = S_WRITE;
            S_WRITE: if (start) state_nxt = S_LOAD;
                     else if (count == LAST) state_nxt = S_FULL;
                     else state_nxt = S_LOAD;
            S_FULL:  if (start) state_nxt = S_LOAD;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            wr_en   <= 1'b0;
            err     <= 1'b0;
            wr_data <= '0;
            wr_addr <= BASE;
            count   <= '0;
        end else begin
            state <= state_nxt;
            // wr_en/err are registered from the handshake, so they are high exactly in WRITE.
            wr_en <= accept;
            err   <= accept && pack_err;
            if (accept) wr_data <= D_WIDTH'(pack_word);
            // A write in progress still commits when start arrives; the pointer rewinds after it.
            if (start) begin
                wr_addr <= BASE;
                count   <= '0;
            end else if (state == S_WRITE) begin
                wr_addr <= wr_addr + A_WIDTH'(4);
                count   <= count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op = '0;
    logic [2:0]  fn3 = '0;
    logic [6:0]  fn7 = '0;
    logic [4:0]  rd = '0;
    logic [4:0]  rs1 = '0;
    logic [4:0]  rs2 = '0;
    logic [31:0] imm = '0;
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic [31:0] wr_data;
    logic [8:0]  count;
    logic        full;
    logic        err;

    int checks = 0;
    int errors = 0;

    instr_encoder #(.D_WIDTH(32), .A_WIDTH(10), .DEPTH(4), .BASE_ADDR(0)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .fn3(fn3), .fn7(fn7), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .count(count),
        .full(full), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Offer one bundle and return 1 ns after the accepting edge (DUT then in WRITE).
    task automatic send(input logic [2:0] o, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                        input logic [31:0] im);
        @(negedge clk);
        op = o; fn3 = f3; fn7 = f7; rd = d; rs1 = s1; rs2 = s2; imm = im;
        in_valid = 1'b1;
        for (int i = 0; i < 20 && !in_ready; i++) @(negedge clk);
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL handshake_timeout in_ready stayed %0b required 1", in_ready);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %0b exp 0", in_ready); end
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %0b exp 0", wr_en); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %0b exp 0", full); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %0b exp 0", err); end
        checks++; if (wr_addr !== 10'd0) begin errors++; $display("FAIL reset_wr_addr got %0d exp 0", wr_addr); end
        checks++; if (wr_data !== 32'h0) begin errors++; $display("FAIL reset_wr_data got %h exp 0", wr_data); end
        checks++; if (count !== 9'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_opimm();
        pulse_start();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL start_in_ready got %0b exp 1", in_ready); end
        send(3'd2, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
        checks++; if (wr_en !== 1'b1) begin errors++; $display("FAIL opimm_wr_en got %0b exp 1", wr_en); end
        checks++; if (wr_addr !== 10'd0) begin errors++; $display("FAIL opimm_addr got %0d exp 0", wr_addr); end
        checks++; if (wr_data !== 32'h00500093) begin errors++; $display("FAIL opimm_data got %h exp 00500093", wr_data); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL opimm_err got %0b exp 0", err); end
        @(posedge clk); #1;
        checks++; if (count !== 9'd1) begin errors++; $display("FAIL opimm_count got %0d exp 1", count); end
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL opimm_wr_en_drop got %0b exp 0", wr_en); end
        checks++; if (wr_data !== 32'h00500093) begin errors++; $display("FAIL opimm_data_hold got %h exp 00500093", wr_data); end
    endtask

    task automatic test_branch_jal();
        pulse_start();
        send(3'd4, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8);
        checks++; if (wr_addr !== 10'd0) begin errors++; $display("FAIL branch_addr got %0d exp 0", wr_addr); end
        checks++; if (wr_data !== 32'h00208463) begin errors++; $display("FAIL branch_data got %h exp 00208463", wr_data); end
        send(3'd5, 3'd7, 7'd0, 5'd1, 5'd0, 5'd0, 32'd16);
        checks++; if (wr_en !== 1'b1) begin errors++; $display("FAIL jal_wr_en got %0b exp 1", wr_en); end
        checks++; if (wr_addr !== 10'd4) begin errors++; $display("FAIL jal_addr got %0d exp 4", wr_addr); end
        checks++; if (wr_data !== 32'h010000EF) begin errors++; $display("FAIL jal_data got %h exp 010000ef", wr_data); end
        @(posedge clk); #1;
        checks++; if (count !== 9'd2) begin errors++; $display("FAIL jal_count got %0d exp 2", count); end
    endtask

    task automatic test_store_illegal();
        pulse_start();
        send(3'd3, 3'b010, 7'd0, 5'd0, 5'd1, 5'd2, 32'd12);
        checks++; if (wr_data !== 32'h0020A623) begin errors++; $display("FAIL store_data got %h exp 0020a623", wr_data); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL store_err got %0b exp 0", err); end
        send(3'd7, 3'd5, 7'h7F, 5'd9, 5'd9, 5'd9, 32'hFFFF_FFFF);
        checks++; if (wr_en !== 1'b1) begin errors++; $display("FAIL illegal_wr_en got %0b exp 1", wr_en); end
        checks++; if (wr_addr !== 10'd4) begin errors++; $display("FAIL illegal_addr got %0d exp 4", wr_addr); end
        checks++; if (wr_data !== 32'h00000013) begin errors++; $display("FAIL illegal_data got %h exp 00000013", wr_data); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL illegal_err got %0b exp 1", err); end
        @(posedge clk); #1;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL illegal_err_pulse got %0b exp 0", err); end
        checks++; if (count !== 9'd2) begin errors++; $display("FAIL illegal_count got %0d exp 2", count); end
    endtask

    task automatic test_full();
        int seen;
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            send(3'd2, 3'd0, 7'd0, 5'(i), 5'd0, 5'd0, 32'(i));
            checks++; if (wr_addr !== 10'(4 * i)) begin errors++; $display("FAIL full_fill_addr%0d got %0d exp %0d", i, wr_addr, 4 * i); end
        end
        @(posedge clk); #1;
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_flag got %0b exp 1", full); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got %0b exp 0", in_ready); end
        checks++; if (count !== 9'd4) begin errors++; $display("FAIL full_count got %0d exp 4", count); end
        seen = 0;
        @(negedge clk);
        in_valid = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            if (wr_en) seen++;
        end
        in_valid = 1'b0;
        checks++; if (seen != 0) begin errors++; $display("FAIL full_ignored writes %0d exp 0", seen); end
        pulse_start();
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL full_clear got %0b exp 0", full); end
        checks++; if (count !== 9'd0) begin errors++; $display("FAIL full_restart_count got %0d exp 0", count); end
        send(3'd2, 3'd0, 7'd0, 5'd3, 5'd0, 5'd0, 32'd1);
        checks++; if (wr_addr !== 10'd0) begin errors++; $display("FAIL full_restart_addr got %0d exp 0", wr_addr); end
        checks++; if (wr_data !== 32'h00100193) begin errors++; $display("FAIL full_restart_data got %h exp 00100193", wr_data); end
        @(posedge clk); #1;
    endtask

    task automatic test_start_in_load();
        // DUT is in LOAD with count 1; start and a valid bundle arrive together.
        @(negedge clk);
        start = 1'b1; in_valid = 1'b1; op = 3'd2;
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b0;
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL start_load_wr_en got %0b exp 0", wr_en); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL start_load_in_ready got %0b exp 1", in_ready); end
        checks++; if (count !== 9'd0) begin errors++; $display("FAIL start_load_count got %0d exp 0", count); end
        @(posedge clk); #1;
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL start_load_dropped got %0b exp 0", wr_en); end
    endtask

    task automatic test_start_in_write();
        send(3'd2, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
        @(posedge clk); #1;
        send(3'd2, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 32'd6);
        checks++; if (wr_addr !== 10'd4) begin errors++; $display("FAIL start_write_addr got %0d exp 4", wr_addr); end
        checks++; if (wr_en !== 1'b1) begin errors++; $display("FAIL start_write_wr_en got %0b exp 1", wr_en); end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++; if (wr_addr !== 10'd0) begin errors++; $display("FAIL start_write_rewind got %0d exp 0", wr_addr); end
        checks++; if (count !== 9'd0) begin errors++; $display("FAIL start_write_count got %0d exp 0", count); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL start_write_in_ready got %0b exp 1", in_ready); end
        checks++; if (wr_data !== 32'h00600113) begin errors++; $display("FAIL start_write_data got %h exp 00600113", wr_data); end
    endtask

    task automatic test_reset_mid_write();
        send(3'd2, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
        @(posedge clk); #1;
        send(3'd2, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd7);
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL rst_write_wr_en got %0b exp 0", wr_en); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_write_in_ready got %0b exp 0", in_ready); end
        checks++; if (count !== 9'd0) begin errors++; $display("FAIL rst_write_count got %0d exp 0", count); end
        checks++; if (wr_addr !== 10'd0) begin errors++; $display("FAIL rst_write_addr got %0d exp 0", wr_addr); end
        checks++; if (wr_data !== 32'h0) begin errors++; $display("FAIL rst_write_data got %h exp 0", wr_data); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_imm_range();
        pulse_start();
        send(3'd2, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd2048);
`ifdef IMM_RANGE_CHECK_EN
        checks++; if (wr_data !== 32'h00000013) begin errors++; $display("FAIL imm2048_data got %h exp 00000013", wr_data); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL imm2048_err got %0b exp 1", err); end
`else
        checks++; if (wr_data !== 32'h80000013) begin errors++; $display("FAIL imm2048_data got %h exp 80000013", wr_data); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL imm2048_err got %0b exp 0", err); end
`endif
        @(posedge clk); #1;
        send(3'd2, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd2047);
        checks++; if (wr_data !== 32'h7FF00013) begin errors++; $display("FAIL imm2047_data got %h exp 7ff00013", wr_data); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL imm2047_err got %0b exp 0", err); end
        @(posedge clk); #1;
        send(3'd2, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'hFFFF_F800);
        checks++; if (wr_data !== 32'h80000013) begin errors++; $display("FAIL immneg_data got %h exp 80000013", wr_data); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL immneg_err got %0b exp 0", err); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_opimm();
        test_branch_jal();
        test_store_illegal();
        test_full();
        test_start_in_load();
        test_start_in_write();
        test_reset_mid_write();
        test_imm_range();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
